// File: rtl/transport_pkg.sv
// Shared definitions for the transport link: header bytes, command
// encoding (common with the send side) and the receive FSM states.
package transport_pkg;

  localparam logic [7:0] HDR_CTRL  = 8'h40;
  localparam logic [7:0] HDR_AUDIO = 8'h80;

  localparam logic [1:0] CMD_IDLE  = 2'd0;
  localparam logic [1:0] CMD_CTRL  = 2'd1;
  localparam logic [1:0] CMD_AUDIO = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    CTRL_HI,
    CTRL_LO,
    AUD_HI,
    AUD_LO,
    PAD,
    DROP
  } rx_state_t;

  // Map a header byte to its command; unknown headers map to CMD_IDLE.
  function automatic logic [1:0] hdr_to_cmd(input logic [7:0] hdr);
    case (hdr)
      HDR_CTRL:  return CMD_CTRL;
      HDR_AUDIO: return CMD_AUDIO;
      default:   return CMD_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous first-word-fall-through sample FIFO. rdata is the head entry
// and is valid whenever empty is low. A pop on an empty FIFO is ignored; a
// push on a full FIFO succeeds only if a pop happens on the same edge.
module sample_fifo #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign rdata   = mem[rd_ptr];

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is 2^AW.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/transport_receive.sv
// Receive end of the transport link: parses one packet per sending frame,
// delivers control words and buffers audio samples in a FWFT FIFO.
// Optional macro TRANSPORT_RX_ERRCNT_EN adds errCount and lastBadHdr.
//
//  state   | meaning
//  IDLE    | waiting for a rising edge of sending
//  HDR     | expecting the header byte
//  CTRL_HI | expecting control word high byte
//  CTRL_LO | expecting control word low byte
//  AUD_HI  | expecting sample high byte
//  AUD_LO  | expecting sample low byte, push on arrival
//  PAD     | consuming pad bytes up to the last index
//  DROP    | consuming bytes of a packet with a bad header
module transport_receive
  import transport_pkg::*;
#(
  parameter int PACKET_BYTES = 16,
  parameter int FIFO_DEPTH   = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    packetIn,
  input  logic                          byteValid,
  input  logic                          sending,
  output logic                          ctrlValid,
  output logic [15:0]                   ctrlData,
  output logic [15:0]                   sampleOut,
  input  logic                          sampleRdEn,
  output logic                          sampleEmpty,
  output logic [$clog2(FIFO_DEPTH):0]   sampleCount,
  output logic                          pktError
`ifdef TRANSPORT_RX_ERRCNT_EN
  ,
  output logic [7:0]                    errCount,
  output logic [7:0]                    lastBadHdr
`endif
);

  localparam int IDX_W = $clog2(PACKET_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(PACKET_BYTES - 1);
  localparam logic [IDX_W-1:0] SAMPLE_END = IDX_W'(PACKET_BYTES - 2);

  rx_state_t        state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             sending_q;
  logic             rise;
  logic [7:0]       hi_q;
  logic             hi_load;
  logic             ctrl_load;
  logic             push;
  logic             full;
  logic             err_nxt;
  logic             ovf_seen, ovf_seen_nxt;
`ifdef TRANSPORT_RX_ERRCNT_EN
  logic             bad_hdr;
`endif

  assign rise = sending & ~sending_q;

  // Next-state, byte index and per-byte actions for the packet parser.
  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    hi_load      = 1'b0;
    ctrl_load    = 1'b0;
    push         = 1'b0;
    err_nxt      = 1'b0;
    ovf_seen_nxt = ovf_seen;
`ifdef TRANSPORT_RX_ERRCNT_EN
    bad_hdr      = 1'b0;
`endif
    if (rise) begin
      // a fresh frame always restarts; an unfinished one is reported
      err_nxt      = (state != IDLE);
      state_nxt    = HDR;
      idx_nxt      = '0;
      ovf_seen_nxt = 1'b0;
    end else if (state != IDLE && !sending) begin
      err_nxt   = 1'b1;
      state_nxt = IDLE;
      idx_nxt   = '0;
    end else if (state != IDLE && byteValid) begin
      idx_nxt = idx + 1'b1;
      case (state)
        HDR: begin
          case (hdr_to_cmd(packetIn))
            CMD_CTRL:  state_nxt = CTRL_HI;
            CMD_AUDIO: state_nxt = AUD_HI;
            default: begin
              state_nxt = DROP;
              err_nxt   = 1'b1;
`ifdef TRANSPORT_RX_ERRCNT_EN
              bad_hdr   = 1'b1;
`endif
            end
          endcase
        end
        CTRL_HI: begin
          hi_load   = 1'b1;
          state_nxt = CTRL_LO;
        end
        CTRL_LO: begin
          ctrl_load = 1'b1;
          state_nxt = PAD;
        end
        AUD_HI: begin
          hi_load   = 1'b1;
          state_nxt = AUD_LO;
        end
        AUD_LO: begin
          push = 1'b1;
          // full with no simultaneous pop: sample is lost, report once
          if (full && !sampleRdEn && !ovf_seen) begin
            err_nxt      = 1'b1;
            ovf_seen_nxt = 1'b1;
          end
          state_nxt = (idx == SAMPLE_END) ? PAD : AUD_HI;
        end
        PAD, DROP: begin
          if (idx == LAST_IDX) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
          end
        end
        default: begin
          state_nxt = IDLE;
          idx_nxt   = '0;
        end
      endcase
    end
  end

  // Parser state, byte latch and registered output pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      // held high so a frame already in progress is not mistaken for a start
      sending_q <= 1'b1;
      hi_q      <= '0;
      ovf_seen  <= 1'b0;
      ctrlValid <= 1'b0;
      ctrlData  <= '0;
      pktError  <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      sending_q <= sending;
      ovf_seen  <= ovf_seen_nxt;
      if (hi_load) hi_q <= packetIn;
      ctrlValid <= ctrl_load;
      if (ctrl_load) ctrlData <= {hi_q, packetIn};
      pktError  <= err_nxt;
    end
  end

`ifdef TRANSPORT_RX_ERRCNT_EN
  // Saturating error tally and capture of the latest invalid header.
  always_ff @(posedge clk) begin
    if (reset) begin
      errCount   <= '0;
      lastBadHdr <= '0;
    end else begin
      if (err_nxt && errCount != 8'hFF) errCount <= errCount + 1'b1;
      if (bad_hdr) lastBadHdr <= packetIn;
    end
  end
`endif

  sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata ({hi_q, packetIn}),
    .pop   (sampleRdEn),
    .rdata (sampleOut),
    .count (sampleCount),
    .empty (sampleEmpty),
    .full  (full)
  );

endmodule

// File: doc/transport_receive.md
Name: transport_receive

Overview:
- Receive end of the transport link. Consumes the byte stream produced by the transport send block, one packet per `sending` frame.
- Parses the header byte of each packet. Control packets yield a 16-bit control word. Audio packets yield 16-bit samples, which are buffered in a sample FIFO for the audio playback path.
- Malformed or truncated packets are discarded and flagged.

Parameters:
- PACKET_BYTES, 16, bytes per packet including header; must be even and ≥4.
- FIFO_DEPTH, 64, sample FIFO entries; power of two.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- packetIn  in  8  received byte; sampled when byteValid=1.
- byteValid  in  1  one-cycle strobe per received byte.
- sending  in  1  frame envelope. Rising edge starts a packet; low aborts any packet in progress.
- ctrlValid  out  1  one-cycle pulse; ctrlData holds a new control word.
- ctrlData  out  16  last received control word.
- sampleOut  out  16  FIFO head sample.
- sampleRdEn  in  1  pop request; ignored when sampleEmpty=1.
- sampleEmpty  out  1  FIFO empty.
- sampleCount  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- pktError  out  1  one-cycle pulse per discarded or faulty packet.

Behaviour:
- Reset (synchronous, active-high):
  - FSM to IDLE; byte counter = 0; FIFO emptied.
  - ctrlValid = 0, ctrlData = 0, pktError = 0, sampleEmpty = 1, sampleCount = 0.
- Packet format:
  - byte0 = header: 8'h40 = control, 8'h80 = audio, anything else is invalid.
  - Control: byte1 = word[15:8], byte2 = word[7:0], remaining bytes are pad (ignored).
  - Audio: bytes 1..PACKET_BYTES-2 are (PACKET_BYTES-2)/2 samples, high byte first. The last byte is pad.
- FSM states: IDLE, HDR, CTRL_HI, CTRL_LO, AUD_HI, AUD_LO, PAD, DROP.
  - IDLE→HDR on a rising edge of sending.
  - HDR: on a byte, 40→CTRL_HI, 80→AUD_HI, other→DROP with pktError pulse.
  - CTRL_HI→CTRL_LO on a byte.
  - CTRL_LO on a byte: ctrlData updates and ctrlValid pulses the following cycle (latency 1 clk after the low byte). Then →PAD.
  - AUD_HI latches the high byte, →AUD_LO.
  - AUD_LO assembles the sample and pushes it to the FIFO in the same edge. Next state is AUD_HI, or PAD once byte index = PACKET_BYTES-2.
  - PAD/DROP consume bytes until index = PACKET_BYTES-1, then →IDLE.
- Byte counter: increments only on byteValid in non-IDLE states; width $clog2(PACKET_BYTES).
- Runt packet (sending falls before the final byte):
  - →IDLE and pktError pulses.
  - Samples already pushed stay in the FIFO.
  - A control word whose CTRL_LO byte has not yet arrived is not delivered.
- Extra bytes: byteValid while IDLE is ignored, as are bytes after the final byte with sending still high. A new packet needs a new rising edge of sending.
- Rising edge of sending while not IDLE: restart at HDR and pulse pktError for the abandoned packet.
- FIFO full on a push: sample is dropped, pktError pulses once for that packet, parsing continues.
- Simultaneous push and pop:
  - Both happen; sampleCount is unchanged.
  - When full, the pop frees space and the push succeeds.
  - When empty, the pop is ignored and the push succeeds.
- sampleOut is first-word-fall-through; it is valid whenever sampleEmpty=0.
- Reset mid-packet: everything is cleared; the next packet needs a fresh rising edge of sending.

Optional Feature:
- TRANSPORT_RX_ERRCNT_EN defined:
  - Adds output errCount[7:0], which increments on each pktError pulse, saturates at 8'hFF and clears on reset.
  - Adds output lastBadHdr[7:0], holding the most recent invalid header byte (reset 0).
- Undefined: neither port exists; pktError is the only error indication.

Decomposition:
- Package transport_pkg:
  - HDR_CTRL = 8'h40, HDR_AUDIO = 8'h80.
  - Command encoding constants CMD_IDLE/CMD_CTRL/CMD_AUDIO, shared with the send side.
  - FSM state enum.
- One sub-module: sample_fifo, a synchronous FWFT FIFO, 16 bits wide, depth FIFO_DEPTH, with count/empty/full outputs.

Test Plan:
- Control packet 40,12,34,pad×13 within one sending frame → single ctrlValid pulse 1 clk after byte2, ctrlData = 16'h1234, no pktError, FIFO unchanged.
- Audio packet 80, then 00 01, 00 02, …, 00 07, then pad → sampleCount = 7; pops return 0001..0007 in order; sampleEmpty after the 7th pop.
- Header 8'h55 followed by 15 bytes → pktError pulse, no ctrlValid, no samples pushed; the next valid control packet is parsed normally.
- Audio frame where sending falls after byte 6 → samples 0001, 0002 and 0003 are in the FIFO (bytes 1–6), the FSM is IDLE and pktError pulses once.
- Fill the FIFO to 64 samples and send one more audio packet with no pops → all 7 samples dropped, a single pktError pulse, count stays 64. Repeat with sampleRdEn held high throughout → count stays 64 and no error.
- Assert reset during CTRL_LO with byteValid=1 → no ctrlValid, ctrlData = 0, FIFO empty. A following clean packet decodes correctly.
